// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate response checker: FSM state encoding,
// error counter width and the standard two-input truth tables.
`timescale 1ns/1ps

package gate_chk_pkg;

    // Width of the mismatch counter and the sample counter.
    localparam int ERR_W = 8;

    // Truth tables indexed by {A,B}; bit 3 is A=1,B=1.
    localparam logic [3:0] TRUTH_NAND = 4'b0111;
    localparam logic [3:0] TRUTH_AND  = 4'b1000;
    localparam logic [3:0] TRUTH_OR   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR  = 4'b0110;

    // Every input pair observed.
    localparam logic [3:0] COV_FULL = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Expected gate output for one input pair under a given truth table.
    function automatic logic expected_out(input logic [3:0] tt, input logic a, input logic b);
        return tt[{a, b}];
    endfunction

    // True when a table is one of the standard gates above.
    function automatic logic is_standard_table(input logic [3:0] tt);
        return (tt == TRUTH_NAND) || (tt == TRUTH_AND) ||
               (tt == TRUTH_OR)   || (tt == TRUTH_XOR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and synchronous clear.
// Clear wins over increment; once all ones, further increments are ignored.
`timescale 1ns/1ps

module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    // Next value: clear, saturating increment, or hold.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != CNT_MAX)) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/gate_response_checker.sv
// Gate response checker: observes samples {A,B,OUT} of a two-input gate,
// compares OUT with TRUTH_TABLE, counts mismatches and tracks which input
// pairs were seen. A run ends on full coverage or after MAX_SAMPLES samples.
// Optional feature: define GATE_CHK_FIRST_ERR_EN to capture the first
// mismatching sample on first_err; otherwise first_err is tied to zero.
`timescale 1ns/1ps

module gate_response_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE = TRUTH_NAND,
    parameter int         MAX_SAMPLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             s_a,
    input  logic             s_b,
    input  logic             s_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       cov_mask,
    output logic [2:0]       first_err
);

    // Sample counter value at which the current sample is the last one.
    localparam logic [ERR_W-1:0] LAST_IDX = ERR_W'(MAX_SAMPLES - 1);

    state_t           state_reg;
    state_t           state_next;

    logic             accept;
    logic             run_start;
    logic             mismatch;
    logic [1:0]       pair_idx;
    logic [3:0]       pair_hit;
    logic [3:0]       cov_reg;
    logic [3:0]       cov_next;
    logic             cov_full_next;
    logic             reach_max;
    logic [ERR_W-1:0] sample_cnt;

    // A start is honoured only outside RUN; it clears all run results.
    assign run_start = start && (state_reg != RUN);
    assign accept    = s_valid && s_ready;
    assign pair_idx  = {s_a, s_b};
    assign mismatch  = (s_out != expected_out(TRUTH_TABLE, s_a, s_b));

    // One-hot decode of the accepted input pair.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pair_hit
            assign pair_hit[gi] = accept && (pair_idx == 2'(gi));
        end
    endgenerate

    assign cov_next      = cov_reg | pair_hit;
    assign cov_full_next = (cov_next == COV_FULL);
    assign reach_max     = accept && (sample_cnt == LAST_IDX);

    // Mismatch counter, saturating at its maximum.
    sat_counter #(
        .WIDTH (ERR_W)
    ) u_err_cnt (
        .clk   (clk),
        .srst  (rst),
        .clr   (run_start),
        .inc   (accept && mismatch),
        .count (err_count)
    );

    // Accepted-sample counter used to end the run at MAX_SAMPLES.
    sat_counter #(
        .WIDTH (ERR_W)
    ) u_sample_cnt (
        .clk   (clk),
        .srst  (rst),
        .clr   (run_start),
        .inc   (accept),
        .count (sample_cnt)
    );

    // Coverage register: one bit per input pair seen in this run.
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            cov_reg <= 4'h0;
        end else begin
            cov_reg <= cov_next;
        end
    end

    assign cov_mask = cov_reg;

`ifdef GATE_CHK_FIRST_ERR_EN
    logic [2:0] first_err_reg;

    // Capture the first mismatch of the run; err_count is still zero then.
    always_ff @(posedge clk) begin
        if (rst || run_start) begin
            first_err_reg <= 3'b000;
        end else if (accept && mismatch && (err_count == '0)) begin
            first_err_reg <= {s_a, s_b, s_out};
        end
    end

    assign first_err = first_err_reg;
`else
    assign first_err = 3'b000;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic; the finishing sample is accepted on the same edge.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (accept && (cov_full_next || reach_max)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs; pass is only meaningful while done.
    always_comb begin
        s_ready = (state_reg == RUN);
        busy    = (state_reg == RUN);
        done    = (state_reg == DONE);
        pass    = (state_reg == DONE) && (err_count == '0) && (cov_reg == COV_FULL);
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: table-driven NAND runs, hand-written
// sequences for dropped samples, ignored starts, reset abort, short and
// long sample budgets, then randomized runs against a sample-list model.
`timescale 1ns/1ps

module tb_gate_response_checker;

    localparam int MAXS = 16;

`ifdef GATE_CHK_FIRST_ERR_EN
    localparam bit FE_EN = 1'b1;
`else
    localparam bit FE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0, start4 = 1'b0, start255 = 1'b0;
    logic s_valid = 1'b0, s_a = 1'b0, s_b = 1'b0, s_out = 1'b0;

    logic       s_ready, busy, done, pass;
    logic [7:0] err_count;
    logic [3:0] cov_mask;
    logic [2:0] first_err;

    logic       s_ready4, busy4, done4, pass4;
    logic [7:0] err_count4;
    logic [3:0] cov_mask4;
    logic [2:0] first_err4;

    logic       s_ready255, busy255, done255, pass255;
    logic [7:0] err_count255;
    logic [3:0] cov_mask255;
    logic [2:0] first_err255;

    gate_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
        .s_a(s_a), .s_b(s_b), .s_out(s_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .cov_mask(cov_mask), .first_err(first_err)
    );

    gate_response_checker #(.TRUTH_TABLE(4'b0111), .MAX_SAMPLES(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .s_valid(s_valid), .s_ready(s_ready4),
        .s_a(s_a), .s_b(s_b), .s_out(s_out), .busy(busy4), .done(done4), .pass(pass4),
        .err_count(err_count4), .cov_mask(cov_mask4), .first_err(first_err4)
    );

    gate_response_checker #(.TRUTH_TABLE(4'b0111), .MAX_SAMPLES(255)) dut255 (
        .clk(clk), .rst(rst), .start(start255), .s_valid(s_valid), .s_ready(s_ready255),
        .s_a(s_a), .s_b(s_b), .s_out(s_out), .busy(busy255), .done(done255), .pass(pass255),
        .err_count(err_count255), .cov_mask(cov_mask255), .first_err(first_err255)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Advance one clock; outputs are then sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic a, input logic b, input logic o);
        s_valid = 1'b1; s_a = a; s_b = b; s_out = o;
        tick();
        s_valid = 1'b0;
    endtask

    // NAND reference in plain logic, independent of any truth-table vector.
    function automatic logic nand_ref(input logic a, input logic b);
        return !(a && b);
    endfunction

    typedef struct {
        bit   new_run;
        logic a, b, o;
        int   exp_err;
        int   exp_cov;
        bit   exp_done;
        bit   exp_pass;
    } vec_t;

    typedef struct {
        logic a, b, o;
    } samp_t;

    samp_t model_q[$];

    // Expected status derived from the list of samples accepted in the run.
    function automatic void model_eval(output int errs, output int cov,
                                       output int fe, output bit fin);
        bit seen = 1'b0;
        errs = 0; cov = 0; fe = 0;
        foreach (model_q[i]) begin
            if (model_q[i].o != nand_ref(model_q[i].a, model_q[i].b)) begin
                if (!seen) fe = {29'd0, model_q[i].a, model_q[i].b, model_q[i].o};
                seen = 1'b1;
                if (errs < 255) errs = errs + 1;
            end
            cov = cov | (1 << (2 * int'(model_q[i].a) + int'(model_q[i].b)));
        end
        fin = (cov == 15) || (model_q.size() >= MAXS);
        if (!FE_EN) fe = 0;
    endfunction

    vec_t vecs[8];

    initial begin
        int errs, cov, fe, cycles;
        bit fin, got_done;
        logic ra, rb, ro, rv;

        // Two NAND runs: all correct, then one wrong response on pair 11.
        vecs[0] = '{1, 0, 0, 1, 0, 4'h1, 0, 0};
        vecs[1] = '{0, 0, 1, 1, 0, 4'h3, 0, 0};
        vecs[2] = '{0, 1, 0, 1, 0, 4'h7, 0, 0};
        vecs[3] = '{0, 1, 1, 0, 0, 4'hF, 1, 1};
        vecs[4] = '{1, 0, 0, 1, 0, 4'h1, 0, 0};
        vecs[5] = '{0, 1, 1, 1, 1, 4'h9, 0, 0};
        vecs[6] = '{0, 0, 1, 1, 1, 4'hB, 0, 0};
        vecs[7] = '{0, 1, 0, 1, 1, 4'hF, 1, 0};

        // Reset and idle state, with a sample offered while idle.
        s_valid = 1'b1; s_a = 1'b1; s_b = 1'b1; s_out = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        s_valid = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_pass", pass, 0);
        check("reset_ready", s_ready, 0);
        check("idle_err_drop", err_count, 0);
        check("idle_cov_drop", cov_mask, 0);
        check("reset_first_err", first_err, 0);

        // Table-driven runs.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].new_run) begin
                pulse_start();
                check($sformatf("v%0d_start_busy", i), busy, 1);
                check($sformatf("v%0d_start_err", i), err_count, 0);
                check($sformatf("v%0d_start_cov", i), cov_mask, 0);
            end
            send(vecs[i].a, vecs[i].b, vecs[i].o);
            check($sformatf("v%0d_err", i), err_count, vecs[i].exp_err);
            check($sformatf("v%0d_cov", i), cov_mask, vecs[i].exp_cov);
            check($sformatf("v%0d_done", i), done, int'(vecs[i].exp_done));
            check($sformatf("v%0d_pass", i), pass, int'(vecs[i].exp_pass));
        end
        check("tbl_first_err", first_err, FE_EN ? 7 : 0);

        // Samples offered in DONE are dropped.
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_a = 1'b1; s_b = 1'b1; s_out = 1'b1;
            #1;
            check("done_ready_low", s_ready, 0);
            tick();
            check("done_err_hold", err_count, 1);
            check("done_flag_hold", done, 1);
        end
        s_valid = 1'b0;

        // Start pulses inside RUN must not restart the run.
        pulse_start();
        send(0, 0, 1);
        pulse_start();
        check("midrun_start_cov", cov_mask, 1);
        check("midrun_start_busy", busy, 1);
        start = 1'b1;
        send(0, 1, 1);
        start = 1'b0;
        check("midrun_start_sample_cov", cov_mask, 3);
        send(1, 0, 1);
        send(1, 1, 0);
        check("midrun_final_done", done, 1);
        check("midrun_final_pass", pass, 1);

        // Reset mid-run, overriding a simultaneous start and sample.
        pulse_start();
        send(1, 1, 1);
        send(0, 1, 1);
        check("prerst_err", err_count, 1);
        rst = 1'b1; start = 1'b1; s_valid = 1'b1; s_a = 1'b0; s_b = 1'b0; s_out = 1'b0;
        tick();
        rst = 1'b0; start = 1'b0; s_valid = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_ready", s_ready, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_cov", cov_mask, 0);
        check("rst_first_err", first_err, 0);
        tick();
        check("rst_stays_idle", busy, 0);
        pulse_start();
        send(1, 1, 0); send(1, 0, 1); send(0, 1, 1); send(0, 0, 1);
        check("postrst_done", done, 1);
        check("postrst_pass", pass, 1);
        check("postrst_err", err_count, 0);

        // Budget of 4: the same correct pair four times, coverage incomplete.
        start4 = 1'b1; tick(); start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(0, 0, 1);
            check($sformatf("max4_done_s%0d", i), done4, (i == 3) ? 1 : 0);
        end
        check("max4_cov", cov_mask4, 1);
        check("max4_pass", pass4, 0);
        check("max4_err", err_count4, 0);
        check("max4_ready_after", s_ready4, 0);

        // Budget of 255, every response wrong: counter reaches its ceiling.
        start255 = 1'b1; tick(); start255 = 1'b0;
        for (int i = 0; i < 255; i++) begin
            send(0, 0, 0);
            if (i == 253) begin
                check("max255_err_254", err_count255, 254);
                check("max255_done_early", done255, 0);
            end
        end
        check("max255_err", err_count255, 255);
        check("max255_done", done255, 1);
        check("max255_pass", pass255, 0);
        check("max255_first_err", first_err255, 0);
        check("main_untouched_err", err_count, 0);
        check("main_untouched_cov", cov_mask, 15);

        // Randomized runs on the default checker.
        for (int r = 0; r < 20; r++) begin
            pulse_start();
            model_q.delete();
            got_done = 1'b0;
            cycles = 0;
            while (!got_done && cycles < 300) begin
                rv = ($urandom_range(0, 3) != 0);
                ra = 1'($urandom_range(0, 1));
                rb = 1'($urandom_range(0, 1));
                ro = nand_ref(ra, rb);
                if ($urandom_range(0, 3) == 0) ro = ~ro;
                s_valid = rv; s_a = ra; s_b = rb; s_out = ro;
                start = ($urandom_range(0, 7) == 0);
                tick();
                s_valid = 1'b0; start = 1'b0;
                cycles++;
                if (rv) model_q.push_back('{ra, rb, ro});
                model_eval(errs, cov, fe, fin);
                if (rv) begin
                    check($sformatf("rnd%0d_err", r), err_count, errs);
                    check($sformatf("rnd%0d_cov", r), cov_mask, cov);
                end
                check($sformatf("rnd%0d_done", r), done, int'(fin));
                if (fin) begin
                    check($sformatf("rnd%0d_pass", r), pass, int'(errs == 0 && cov == 15));
                    check($sformatf("rnd%0d_first_err", r), first_err, fe);
                    check($sformatf("rnd%0d_busy_end", r), busy, 0);
                    got_done = 1'b1;
                end
            end
            if (!got_done) check($sformatf("rnd%0d_timeout", r), 0, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
